// File: rtl/arghunter_pkg.sv
// Shared types and default tuning constants for the arghunter input front end.
package arghunter_pkg;

  typedef struct packed {
    logic       rise;
    logic [2:0] idx;
  } evt_t;

  localparam logic EVT_RISE = 1'b1;
  localparam logic EVT_FALL = 1'b0;

  localparam int PRESC_DIV_DEF  = 1000;
  localparam int DEB_COUNT_DEF  = 8;
  localparam int DEB_W_DEF      = 4;
  localparam int FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/arghunter_debounce_bit.sv
// One-bit tick-sampled debouncer: level flips after DEB_COUNT consecutive differing ticks.
// rise/fall pulse for the single cycle following the flip; no backpressure.
module arghunter_debounce_bit
  import arghunter_pkg::*;
#(
  parameter int DEB_COUNT = DEB_COUNT_DEF,
  parameter int DEB_W     = DEB_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_bit,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [DEB_W-1:0] cnt;
  logic             flip;

  assign flip = tick && (sync_bit != level) && (cnt == DEB_W'(DEB_COUNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= flip && !level;
      fall <= flip && level;
      // Any tick agreeing with the stable level restarts the run; a flip also restarts it.
      if (tick) begin
        if ((sync_bit == level) || flip) cnt <= '0;
        else                             cnt <= cnt + 1'b1;
      end
      if (flip) level <= ~level;
    end
  end

endmodule

// File: rtl/arghunter_input_frontend.sv
// Pin conditioning: 2-FF sync, per-bit debounce, edge detect, priority-merged event FIFO.
// Debounced edge reaches evt_valid 2 cycles after the level flip; evt_ready low holds the head and queues edges as pending.
module arghunter_input_frontend
  import arghunter_pkg::*;
#(
  parameter int PRESC_DIV  = PRESC_DIV_DEF,
  parameter int DEB_COUNT  = DEB_COUNT_DEF,
  parameter int DEB_W      = DEB_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic       clear_ovf,
  output logic [7:0] btn_level,
  output logic [7:0] btn_rise,
  output logic [7:0] btn_fall,
  output logic       evt_valid,
  output logic [3:0] evt_data,
  input  logic       evt_ready,
  output logic       evt_overflow
);

  localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  // Prescaler
  logic [PRESC_W-1:0] presc_cnt;
  logic               tick;

  assign tick = ena && (presc_cnt == PRESC_W'(PRESC_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   presc_cnt <= '0;
    else if (ena) presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
  end

  // Synchroniser
  logic [7:0] sync_q1, sync_q2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= ui_in;
      sync_q2 <= sync_q1;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_deb
    arghunter_debounce_bit #(
      .DEB_COUNT (DEB_COUNT),
      .DEB_W     (DEB_W)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .sync_bit (sync_q2[i]),
      .tick     (tick),
      .level    (btn_level[i]),
      .rise     (btn_rise[i]),
      .fall     (btn_fall[i])
    );
  end

  // The edge pulse counts as pending in its own cycle, so a fresh edge can be pushed immediately.
  logic [7:0] pend_rise, pend_fall;
  logic [7:0] req_rise, req_fall;
  logic [7:0] clr_rise, clr_fall;
  logic       sel_vld;
  evt_t       sel_evt;
  logic       push, pop, full;
  logic       ovf_set;

  assign req_rise = pend_rise | btn_rise;
  assign req_fall = pend_fall | btn_fall;
  assign ovf_set  = |(pend_rise & btn_rise) || |(pend_fall & btn_fall);

  // Scan high to low so the last hit wins: lowest index, rise over fall.
  always_comb begin
    sel_vld = 1'b0;
    sel_evt = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req_fall[i]) begin
        sel_vld = 1'b1;
        sel_evt = '{rise: EVT_FALL, idx: 3'(i)};
      end
      if (req_rise[i]) begin
        sel_vld = 1'b1;
        sel_evt = '{rise: EVT_RISE, idx: 3'(i)};
      end
    end
  end

  always_comb begin
    clr_rise = '0;
    clr_fall = '0;
    if (push) begin
      if (sel_evt.rise == EVT_RISE) clr_rise[sel_evt.idx] = 1'b1;
      else                          clr_fall[sel_evt.idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_rise    <= '0;
      pend_fall    <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend_rise <= req_rise & ~clr_rise;
      pend_fall <= req_fall & ~clr_fall;
      if (ovf_set)        evt_overflow <= 1'b1;
      else if (clear_ovf) evt_overflow <= 1'b0;
    end
  end

  // Event FIFO
  evt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign push      = sel_vld && (!full || pop);
  assign evt_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= sel_evt;
        wr_ptr      <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_arghunter_input_frontend.sv
// Directed bench for the arghunter input front end (PRESC_DIV=4, DEB_COUNT=3).
module tb_arghunter_input_frontend;

  logic       clk = 1'b0;
  logic       rst_n, ena, clear_ovf, evt_ready;
  logic [7:0] ui_in;
  logic [7:0] btn_level, btn_rise, btn_fall;
  logic       evt_valid, evt_overflow;
  logic [3:0] evt_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arghunter_input_frontend #(
    .PRESC_DIV  (4),
    .DEB_COUNT  (3),
    .DEB_W      (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .ui_in        (ui_in),
    .clear_ovf    (clear_ovf),
    .btn_level    (btn_level),
    .btn_rise     (btn_rise),
    .btn_fall     (btn_fall),
    .evt_valid    (evt_valid),
    .evt_data     (evt_data),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for a head event and consumes it; caller holds evt_ready=1.
  task automatic wait_evt(input int budget, output logic got, output logic [3:0] d);
    got = 1'b0;
    d   = 4'h0;
    for (int c = 0; c < budget; c++) begin
      if (evt_valid) begin
        got = 1'b1;
        d   = evt_data;
        break;
      end
      step(1);
    end
    if (got) step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; ui_in = 8'hFF; clear_ovf = 1'b0; evt_ready = 1'b0;
    step(3);
    total++;
    if ({btn_level, btn_rise, btn_fall, evt_valid, evt_data, evt_overflow} !== 30'h0) begin
      bad++;
      $display("FAIL reset_outputs: level=%h rise=%h fall=%h vld=%b dat=%h ovf=%b, need all 0",
               btn_level, btn_rise, btn_fall, evt_valid, evt_data, evt_overflow);
    end
    rst_n = 1'b1;
    step(1);
    total++;
    if ((btn_rise | btn_fall | btn_level) !== 8'h00) begin
      bad++;
      $display("FAIL reset_release_quiet: rise=%h fall=%h level=%h, need 00", btn_rise, btn_fall, btn_level);
    end
  endtask

  task automatic test_power_on();
    logic got; logic [3:0] d;
    int at = -1;
    logic [7:0] rise_at = 8'h00;
    for (int n = 2; n <= 20; n++) begin
      step(1);
      if (at < 0 && btn_level === 8'hFF) begin
        at = n;
        rise_at = btn_rise;
      end
    end
    total++;
    if (at < 0 || at > 18) begin
      bad++;
      $display("FAIL pwr_level_time: level=FF reached at cycle %0d, need 1..18", at);
    end
    total++;
    if (rise_at !== 8'hFF) begin
      bad++;
      $display("FAIL pwr_rise_pulse: rise=%h with level flip, need FF", rise_at);
    end
    step(6);
    total++;
    if (evt_valid !== 1'b1 || evt_data !== 4'h8 || evt_overflow !== 1'b0) begin
      bad++;
      $display("FAIL pwr_held_head: vld=%b dat=%h ovf=%b, need 1 8 0", evt_valid, evt_data, evt_overflow);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_evt(6, got, d);
      total++;
      if (!got || d !== 4'(8 + k)) begin
        bad++;
        $display("FAIL pwr_drain[%0d]: got=%b data=%h, need %h", k, got, d, 4'(8 + k));
      end
    end
    step(5);
    total++;
    if (evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL pwr_drained_empty: vld=%b, need 0", evt_valid);
    end
  endtask

  task automatic test_bounce();
    logic got; logic [3:0] d;
    int seen = 0;
    evt_ready = 1'b1;
    ui_in[3] = 1'b0;
    wait_evt(40, got, d);
    total++;
    if (!got || d !== 4'h3) begin
      bad++;
      $display("FAIL bounce_fall3: got=%b data=%h, need 3", got, d);
    end
    for (int t = 0; t < 8; t++) begin
      ui_in[3] = ~ui_in[3];
      for (int c = 0; c < 5; c++) begin
        step(1);
        if (evt_valid || btn_rise[3] || btn_level[3]) seen++;
      end
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL bounce_quiet: %0d cycles showed activity, need 0", seen);
    end
    ui_in[3] = 1'b1;
    wait_evt(40, got, d);
    total++;
    if (!got || d !== 4'hB) begin
      bad++;
      $display("FAIL bounce_settle: got=%b data=%h, need B", got, d);
    end
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (evt_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL bounce_single: %0d extra valid cycles, need 0", seen);
    end
  endtask

  task automatic test_simultaneous();
    logic got; logic [3:0] d;
    ui_in[1] = 1'b0; ui_in[5] = 1'b0;
    wait_evt(40, got, d);
    total++;
    if (!got || d !== 4'h1 || evt_valid !== 1'b1 || evt_data !== 4'h5) begin
      bad++;
      $display("FAIL sim_falls: first=%h(got %b) next vld=%b dat=%h, need 1 then 5", d, got, evt_valid, evt_data);
    end
    wait_evt(2, got, d);
    ui_in[1] = 1'b1; ui_in[5] = 1'b1;
    wait_evt(40, got, d);
    total++;
    if (!got || d !== 4'h9) begin
      bad++;
      $display("FAIL sim_rise_first: got=%b data=%h, need 9", got, d);
    end
    total++;
    if (evt_valid !== 1'b1 || evt_data !== 4'hD) begin
      bad++;
      $display("FAIL sim_rise_next_beat: vld=%b dat=%h, need 1 D", evt_valid, evt_data);
    end
    wait_evt(2, got, d);
  endtask

  task automatic test_backpressure();
    logic got; logic [3:0] d;
    logic [3:0] exp_q [7] = '{4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'h4, 4'hD};
    int unstable = 0;
    ui_in = 8'h00;
    for (int k = 0; k < 8; k++) begin
      wait_evt(40, got, d);
      total++;
      if (!got || d !== 4'(k)) begin
        bad++;
        $display("FAIL bp_fall_order[%0d]: got=%b data=%h, need %h", k, got, d, 4'(k));
      end
    end
    evt_ready = 1'b0;
    for (int b = 0; b < 6; b++) begin
      ui_in[b] = 1'b1;
      for (int c = 0; c < 25; c++) begin
        step(1);
        if (evt_valid && evt_data !== 4'h8) unstable++;
      end
    end
    total++;
    if (evt_valid !== 1'b1 || unstable != 0 || evt_overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_hold: vld=%b unstable=%0d ovf=%b, need 1 0 0", evt_valid, unstable, evt_overflow);
    end
    ui_in[4] = 1'b0;
    step(25);
    total++;
    if (evt_overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_fall_no_ovf: ovf=%b, need 0", evt_overflow);
    end
    ui_in[4] = 1'b1;
    step(25);
    total++;
    if (evt_overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_merge_ovf: ovf=%b, need 1", evt_overflow);
    end
    clear_ovf = 1'b1;
    step(1);
    clear_ovf = 1'b0;
    total++;
    if (evt_overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_clear_ovf: ovf=%b, need 0", evt_overflow);
    end
    evt_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      wait_evt(6, got, d);
      total++;
      if (!got || d !== exp_q[k]) begin
        bad++;
        $display("FAIL bp_drain[%0d]: got=%b data=%h, need %h", k, got, d, exp_q[k]);
      end
    end
    step(10);
    total++;
    if (evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain_empty: vld=%b, need 0", evt_valid);
    end
  endtask

  task automatic test_ena();
    logic got; logic [3:0] d;
    int seen = 0;
    evt_ready = 1'b0;
    ui_in[2] = 1'b0;
    for (int c = 0; c < 30 && btn_level[2] !== 1'b0; c++) step(1);
    step(3);
    total++;
    if (evt_valid !== 1'b1 || evt_data !== 4'h2) begin
      bad++;
      $display("FAIL ena_queued: vld=%b dat=%h, need 1 2", evt_valid, evt_data);
    end
    ena = 1'b0; ui_in[2] = 1'b1; evt_ready = 1'b1;
    wait_evt(3, got, d);
    total++;
    if (!got || d !== 4'h2) begin
      bad++;
      $display("FAIL ena_pop_disabled: got=%b data=%h, need 2", got, d);
    end
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (evt_valid || btn_level[2]) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL ena_frozen: %0d active cycles, need 0", seen);
    end
    ena = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step(1);
      if (evt_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL ena_early_evt: %0d valid cycles before 3 ticks, need 0", seen);
    end
    wait_evt(30, got, d);
    total++;
    if (!got || d !== 4'hA) begin
      bad++;
      $display("FAIL ena_resume_evt: got=%b data=%h, need A", got, d);
    end
  endtask

  task automatic test_reset_mid();
    logic got; logic [3:0] d;
    int seen = 0;
    evt_ready = 1'b0;
    ui_in[0] = 1'b0; ui_in[1] = 1'b0; ui_in[7] = 1'b1;
    step(25);
    total++;
    if (evt_valid !== 1'b1 || evt_data !== 4'h0) begin
      bad++;
      $display("FAIL rst_queued: vld=%b dat=%h, need 1 0", evt_valid, evt_data);
    end
    #3 rst_n = 1'b0;
    #1;
    total++;
    if (evt_valid !== 1'b0 || btn_level !== 8'h00) begin
      bad++;
      $display("FAIL rst_async: vld=%b level=%h, need 0 00", evt_valid, btn_level);
    end
    ui_in = 8'h00;
    step(3);
    rst_n = 1'b1;
    step(1);
    total++;
    if ((btn_rise | btn_fall) !== 8'h00 || evt_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_release_pulse: rise=%h fall=%h vld=%b, need 00 00 0", btn_rise, btn_fall, evt_valid);
    end
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (evt_valid || btn_level !== 8'h00) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rst_no_stale: %0d active cycles, need 0", seen);
    end
    ui_in[6] = 1'b1;
    evt_ready = 1'b1;
    wait_evt(40, got, d);
    total++;
    if (!got || d !== 4'hE) begin
      bad++;
      $display("FAIL rst_new_edge: got=%b data=%h, need E", got, d);
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_bounce();
    test_simultaneous();
    test_backpressure();
    test_ena();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
    $fatal(1);
  end

endmodule
